// File: rtl/exec_unit_if.sv
// Issue/complete bus between the core pipeline and exec_unit.
// Forwarding channels are flattened: channel i uses fwd_key[i*KEYW +: KEYW] and fwd_value[i*XLEN +: XLEN].
interface exec_unit_if #(
  parameter int XLEN      = 32,
  parameter int FWD_PORTS = 2,
  parameter int KEYW      = 5
);
  logic                      enabled;
  logic [5:0]                op;
  logic [KEYW-1:0]           rs1_key, rs2_key;
  logic [XLEN-1:0]           rs1_val, rs2_val, imm, pc;
  logic [FWD_PORTS-1:0]      fwd_valid;
  logic [FWD_PORTS*KEYW-1:0] fwd_key;
  logic [FWD_PORTS*XLEN-1:0] fwd_value;
  logic                      flush;
  logic                      busy, completed;
  logic [XLEN-1:0]           result;

  modport master (output enabled, op, rs1_key, rs2_key, rs1_val, rs2_val, imm, pc,
                         fwd_valid, fwd_key, fwd_value, flush,
                  input  busy, completed, result);
  modport slave  (input  enabled, op, rs1_key, rs2_key, rs1_val, rs2_val, imm, pc,
                         fwd_valid, fwd_key, fwd_value, flush,
                  output busy, completed, result);
endinterface

// File: rtl/exec_unit.sv
// EX-stage integer unit: single-cycle RV32I ops, plus a multi-cycle multiplier and a
// restoring divider that are built only when EXEC_MULDIV_EN is defined.
module exec_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int FWD_PORTS  = 2,
  parameter int KEYW       = 5
) (
  input logic        clk,
  input logic        rstn,
  exec_unit_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t          r_state, w_next;
  logic [XLEN-1:0] r_result, w_res_d, w_alu, w_a, w_b;
  logic            w_ld, w_start;

  // Lowest-index matching forward channel wins; key 0 is the hardwired zero register.
  function automatic logic [XLEN-1:0] sel_opnd(input logic [KEYW-1:0] key,
      input logic [XLEN-1:0] rf, input logic [FWD_PORTS-1:0] vld,
      input logic [FWD_PORTS*KEYW-1:0] keys, input logic [FWD_PORTS*XLEN-1:0] vals);
    logic [XLEN-1:0] v;
    v = rf;
    for (int i = FWD_PORTS-1; i >= 0; i--)
      if (vld[i] && keys[i*KEYW +: KEYW] == key) v = vals[i*XLEN +: XLEN];
    if (key == '0) v = '0;
    return v;
  endfunction

  assign w_a = sel_opnd(bus.rs1_key, bus.rs1_val, bus.fwd_valid, bus.fwd_key, bus.fwd_value);
  assign w_b = sel_opnd(bus.rs2_key, bus.rs2_val, bus.fwd_valid, bus.fwd_key, bus.fwd_value);

  always_comb begin
    w_alu = '0;
    case (bus.op)
      6'd0:  w_alu = bus.imm;
      6'd1:  w_alu = bus.pc + bus.imm;
      6'd2:  w_alu = bus.pc + XLEN'(4);
      6'd3:  w_alu = XLEN'(w_a == w_b);
      6'd4:  w_alu = XLEN'(w_a != w_b);
      6'd5:  w_alu = XLEN'($signed(w_a) < $signed(w_b));
      6'd6:  w_alu = XLEN'($signed(w_a) >= $signed(w_b));
      6'd7:  w_alu = XLEN'(w_a < w_b);
      6'd8:  w_alu = XLEN'(w_a >= w_b);
      6'd9,
      6'd10: w_alu = w_a + bus.imm;
      6'd11: w_alu = XLEN'($signed(w_a) < $signed(bus.imm));
      6'd12: w_alu = XLEN'(w_a < bus.imm);
      6'd13: w_alu = w_a ^ bus.imm;
      6'd14: w_alu = w_a | bus.imm;
      6'd15: w_alu = w_a & bus.imm;
      6'd16: w_alu = w_a << bus.imm[SHW-1:0];
      6'd17: w_alu = w_a >> bus.imm[SHW-1:0];
      6'd18: w_alu = $signed(w_a) >>> bus.imm[SHW-1:0];
      6'd19: w_alu = w_a + w_b;
      6'd20: w_alu = w_a - w_b;
      6'd21: w_alu = w_a << w_b[SHW-1:0];
      6'd22: w_alu = XLEN'($signed(w_a) < $signed(w_b));
      6'd23: w_alu = XLEN'(w_a < w_b);
      6'd24: w_alu = w_a ^ w_b;
      6'd25: w_alu = w_a >> w_b[SHW-1:0];
      6'd26: w_alu = $signed(w_a) >>> w_b[SHW-1:0];
      6'd27: w_alu = w_a | w_b;
      6'd28: w_alu = w_a & w_b;
      default: w_alu = '0;
    endcase
  end

`ifdef EXEC_MULDIV_EN
  localparam int MCW = $clog2(MUL_STAGES + 1);
  localparam int DCW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic              w_is_mul, w_is_div, w_msa, w_msb;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res, r_prod;
  logic [MCW-1:0]    r_mcnt;

  assign w_is_mul  = bus.op >= 6'd29 && bus.op <= 6'd32;
  assign w_is_div  = bus.op >= 6'd33 && bus.op <= 6'd36;
  // Extending each operand by its signedness makes one unsigned 2*XLEN product serve all four forms.
  assign w_msa     = (bus.op == 6'd30 || bus.op == 6'd31) && w_a[XLEN-1];
  assign w_msb     = (bus.op == 6'd30) && w_b[XLEN-1];
  assign w_prod    = {{XLEN{w_msa}}, w_a} * {{XLEN{w_msb}}, w_b};
  assign w_mul_res = (bus.op == 6'd29) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  logic            w_dsgn, w_drem, w_na, w_nb, w_dz, w_ovf;
  logic [XLEN-1:0] w_spec, w_dfix, r_rem, r_quo, r_dvs;
  logic [XLEN:0]   w_shift, w_diff;
  logic [DCW-1:0]  r_dcnt;
  logic            r_dspec, r_negq, r_negr, r_drem;

  assign w_dsgn  = bus.op == 6'd33 || bus.op == 6'd35;
  assign w_drem  = bus.op == 6'd35 || bus.op == 6'd36;
  assign w_na    = w_dsgn && w_a[XLEN-1];
  assign w_nb    = w_dsgn && w_b[XLEN-1];
  assign w_dz    = w_b == '0;
  assign w_ovf   = w_dsgn && w_a == MIN && w_b == '1;
  // Overflow quotient equals the dividend (MIN), so w_a covers both special quotients' non-ones case.
  assign w_spec  = w_dz ? (w_drem ? w_a : '1) : (w_drem ? '0 : w_a);
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_dfix  = r_drem ? (r_negr ? -r_rem : r_rem) : (r_negq ? -r_quo : r_quo);
`endif

  assign w_start = bus.enabled && !bus.flush && (r_state == IDLE || r_state == DONE);

  always_comb begin
    w_next  = r_state;
    w_ld    = 1'b0;
    w_res_d = w_alu;
    case (r_state)
      IDLE, DONE: begin
        w_next = IDLE;
        if (w_start) begin
`ifdef EXEC_MULDIV_EN
          if (w_is_mul && MUL_STAGES > 1) w_next = MUL;
          else if (w_is_div)              w_next = DIV;
          else begin
            w_ld    = 1'b1;
            w_next  = DONE;
            w_res_d = w_is_mul ? w_mul_res : w_alu;
          end
`else
          w_ld   = 1'b1;
          w_next = DONE;
`endif
        end
      end
`ifdef EXEC_MULDIV_EN
      MUL: if (r_mcnt == '0) begin
        w_ld    = 1'b1;
        w_res_d = r_prod;
        w_next  = DONE;
      end
      DIV: if (r_dspec || r_dcnt == '0) begin
        w_ld    = 1'b1;
        w_res_d = r_dspec ? r_quo : w_dfix;
        w_next  = DONE;
      end
`endif
      default: w_next = IDLE;
    endcase
    if (bus.flush) begin
      w_next = IDLE;
      w_ld   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_result <= '0;
`ifdef EXEC_MULDIV_EN
      r_prod  <= '0;
      r_mcnt  <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_dcnt  <= '0;
      r_dspec <= 1'b0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_drem  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_ld) r_result <= w_res_d;
`ifdef EXEC_MULDIV_EN
      if (w_start && w_is_mul) begin
        r_prod <= w_mul_res;
        r_mcnt <= MCW'(MUL_STAGES - 2);
      end else if (r_state == MUL && r_mcnt != '0) begin
        r_mcnt <= r_mcnt - 1'b1;
      end
      // Special cases park their final answer in r_quo and finish on the next edge.
      if (w_start && w_is_div) begin
        r_quo   <= (w_dz || w_ovf) ? w_spec : (w_na ? -w_a : w_a);
        r_dvs   <= w_nb ? -w_b : w_b;
        r_rem   <= '0;
        r_dcnt  <= DCW'(XLEN);
        r_dspec <= w_dz || w_ovf;
        r_negq  <= w_na ^ w_nb;
        r_negr  <= w_na;
        r_drem  <= w_drem;
      end else if (r_state == DIV && !r_dspec && r_dcnt != '0) begin
        r_rem  <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
        r_quo  <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
        r_dcnt <= r_dcnt - 1'b1;
      end
`endif
    end
  end

`ifdef EXEC_MULDIV_EN
  assign bus.busy = (r_state == MUL) || (r_state == DIV);
`else
  assign bus.busy = 1'b0;
`endif
  assign bus.completed = (r_state == DONE);
  assign bus.result    = r_result;
endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit (XLEN=32, MUL_STAGES=2); mul/div scenarios run when EXEC_MULDIV_EN is defined.
module tb_exec_unit;
  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  exec_unit_if #(.XLEN(32), .FWD_PORTS(2), .KEYW(5)) bus ();
  exec_unit #(.XLEN(32), .MUL_STAGES(2), .FWD_PORTS(2), .KEYW(5)) dut (
    .clk(clk), .rstn(rstn), .bus(bus));

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a, b, imm, pc, exp;
  } vec_t;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, b, imm, pc);
    bus.op = op; bus.rs1_key = 5'd1; bus.rs2_key = 5'd2;
    bus.rs1_val = a; bus.rs2_val = b; bus.imm = imm; bus.pc = pc;
    bus.fwd_valid = '0; bus.enabled = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    bus.enabled = 1'b1; bus.op = 6'd19; bus.flush = 1'b0;
    bus.rs1_key = 5'd1; bus.rs2_key = 5'd2; bus.rs1_val = 32'd7; bus.rs2_val = 32'd9;
    bus.imm = '0; bus.pc = '0; bus.fwd_valid = '0; bus.fwd_key = '0; bus.fwd_value = '0;
    tick; tick;
    checks++; if (bus.completed !== 1'b0) begin failures++; $display("FAIL reset_completed got=%b want=0", bus.completed); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=0", bus.result); end
    bus.enabled = 1'b0; rstn = 1'b1;
    tick;
  endtask

  task automatic test_addi;
    drive(6'd10, 32'd5, 32'd0, 32'hFFFF_FFF9, 32'd0);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL addi_busy_start got=%b want=0", bus.busy); end
    tick; bus.enabled = 1'b0;
    checks++; if (bus.completed !== 1'b1) begin failures++; $display("FAIL addi_completed got=%b want=1", bus.completed); end
    checks++; if (bus.result !== 32'hFFFF_FFFE) begin failures++; $display("FAIL addi_result got=%h want=fffffffe", bus.result); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL addi_busy got=%b want=0", bus.busy); end
    tick;
    checks++; if (bus.completed !== 1'b0) begin failures++; $display("FAIL addi_single_pulse got=%b want=0", bus.completed); end
    checks++; if (bus.result !== 32'hFFFF_FFFE) begin failures++; $display("FAIL addi_hold got=%h want=fffffffe", bus.result); end
  endtask

  task automatic test_back_to_back;
    drive(6'd26, 32'h8000_0010, 32'd4, 32'd0, 32'd0);
    tick;
    checks++; if (bus.completed !== 1'b1 || bus.result !== 32'hF800_0001) begin failures++; $display("FAIL sra got=%h/%b want=f8000001/1", bus.result, bus.completed); end
    drive(6'd23, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0);
    tick; bus.enabled = 1'b0;
    checks++; if (bus.completed !== 1'b1 || bus.result !== 32'd1) begin failures++; $display("FAIL sltu_b2b got=%h/%b want=1/1", bus.result, bus.completed); end
    tick;
  endtask

  task automatic test_alu_table;
    vec_t vt [11];
    vt = '{
      '{6'd0,  32'd0,          32'd0,       32'h1234_5000, 32'd0,      32'h1234_5000},
      '{6'd1,  32'd0,          32'd0,       32'h10,        32'h1000,   32'h1010},
      '{6'd2,  32'd0,          32'd0,       32'd0,         32'h1000,   32'h1004},
      '{6'd5,  32'hFFFF_FFFF,  32'd1,       32'd0,         32'd0,      32'd1},
      '{6'd7,  32'hFFFF_FFFF,  32'd1,       32'd0,         32'd0,      32'd0},
      '{6'd20, 32'd3,          32'd5,       32'd0,         32'd0,      32'hFFFF_FFFE},
      '{6'd21, 32'd1,          32'h21,      32'd0,         32'd0,      32'd2},
      '{6'd18, 32'h8000_0000,  32'd0,       32'h1F,        32'd0,      32'hFFFF_FFFF},
      '{6'd12, 32'd1,          32'd0,       32'hFFFF_FFFF, 32'd0,      32'd1},
      '{6'd9,  32'h100,        32'd0,       32'hFFFF_FFFC, 32'd0,      32'hFC},
      '{6'd63, 32'd5,          32'd6,       32'd7,         32'd8,      32'd0}
    };
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].op, vt[i].a, vt[i].b, vt[i].imm, vt[i].pc);
      tick;
      checks++;
      if (bus.completed !== 1'b1 || bus.result !== vt[i].exp)
        begin failures++; $display("FAIL alu_op%0d got=%h/%b want=%h/1", vt[i].op, bus.result, bus.completed, vt[i].exp); end
    end
    bus.enabled = 1'b0;
    tick;
  endtask

  task automatic test_forward;
    bus.op = 6'd19; bus.rs1_key = 5'd3; bus.rs1_val = 32'd99; bus.rs2_key = 5'd4; bus.rs2_val = 32'd1;
    bus.fwd_valid = 2'b11; bus.fwd_key = {5'd3, 5'd3}; bus.fwd_value = {32'd20, 32'd10};
    bus.enabled = 1'b1;
    tick;
    checks++; if (bus.result !== 32'd11) begin failures++; $display("FAIL fwd_lowest got=%0d want=11", bus.result); end
    bus.rs1_key = 5'd0;
    tick;
    checks++; if (bus.result !== 32'd1) begin failures++; $display("FAIL fwd_key0 got=%0d want=1", bus.result); end
    bus.rs1_key = 5'd3; bus.fwd_valid = 2'b10;
    tick;
    checks++; if (bus.result !== 32'd21) begin failures++; $display("FAIL fwd_ch1 got=%0d want=21", bus.result); end
    bus.fwd_valid = 2'b00;
    tick; bus.enabled = 1'b0;
    checks++; if (bus.result !== 32'd100) begin failures++; $display("FAIL fwd_none got=%0d want=100", bus.result); end
    tick;
  endtask

  task automatic test_flush_priority;
    drive(6'd19, 32'd2, 32'd3, 32'd0, 32'd0);
    bus.flush = 1'b1;
    tick; bus.flush = 1'b0; bus.enabled = 1'b0;
    checks++; if (bus.completed !== 1'b0) begin failures++; $display("FAIL flush_prio_completed got=%b want=0", bus.completed); end
    checks++; if (bus.result !== 32'd100) begin failures++; $display("FAIL flush_prio_result got=%0d want=100", bus.result); end
  endtask

`ifdef EXEC_MULDIV_EN
  task automatic test_mul;
    vec_t vt [3];
    drive(6'd30, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0);
    tick;
    checks++; if (bus.busy !== 1'b1 || bus.completed !== 1'b0) begin failures++; $display("FAIL mulh_busy got=%b/%b want=1/0", bus.busy, bus.completed); end
    drive(6'd19, 32'd1, 32'd1, 32'd0, 32'd0);
    tick; bus.enabled = 1'b0;
    checks++; if (bus.completed !== 1'b1 || bus.busy !== 1'b0 || bus.result !== 32'h4000_0000)
      begin failures++; $display("FAIL mulh_done got=%h/%b/%b want=40000000/1/0", bus.result, bus.completed, bus.busy); end
    tick;
    checks++; if (bus.completed !== 1'b0 || bus.result !== 32'h4000_0000) begin failures++; $display("FAIL mulh_ignored_start got=%h/%b want=40000000/0", bus.result, bus.completed); end
    vt = '{
      '{6'd29, 32'hFFFF_FFFF, 32'd3,         32'd0, 32'd0, 32'hFFFF_FFFD},
      '{6'd32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFE},
      '{6'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF}
    };
    for (int i = 0; i < 3; i++) begin
      drive(vt[i].op, vt[i].a, vt[i].b, 32'd0, 32'd0);
      tick; bus.enabled = 1'b0; tick;
      checks++; if (bus.completed !== 1'b1 || bus.result !== vt[i].exp)
        begin failures++; $display("FAIL mul_op%0d got=%h/%b want=%h/1", vt[i].op, bus.result, bus.completed, vt[i].exp); end
    end
    tick;
  endtask

  task automatic test_div;
    vec_t vt [5];
    int lat;
    vt = '{
      '{6'd33, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd2,  32'h8000_0000},
      '{6'd34, 32'd7,         32'd0,         32'd0, 32'd2,  32'hFFFF_FFFF},
      '{6'd35, 32'hFFFF_FFF9, 32'd2,         32'd0, 32'd34, 32'hFFFF_FFFF},
      '{6'd36, 32'd100,       32'd7,         32'd0, 32'd34, 32'd2},
      '{6'd33, 32'hFFFF_FFF9, 32'd2,         32'd0, 32'd34, 32'hFFFF_FFFD}
    };
    for (int i = 0; i < 5; i++) begin
      drive(vt[i].op, vt[i].a, vt[i].b, 32'd0, 32'd0);
      tick; bus.enabled = 1'b0;
      lat = 1;
      while (bus.completed !== 1'b1 && lat < 40) begin tick; lat++; end
      checks++; if (lat !== int'(vt[i].pc)) begin failures++; $display("FAIL div_op%0d_latency got=%0d want=%0d", vt[i].op, lat, vt[i].pc); end
      checks++; if (bus.result !== vt[i].exp) begin failures++; $display("FAIL div_op%0d_result got=%h want=%h", vt[i].op, bus.result, vt[i].exp); end
      tick;
    end
  endtask

  task automatic test_flush_div;
    int seen;
    drive(6'd34, 32'd100, 32'd3, 32'd0, 32'd0);
    tick; bus.enabled = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL divu_busy got=%b want=1", bus.busy); end
    for (int i = 0; i < 9; i++) tick;
    bus.flush = 1'b1;
    tick; bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.completed !== 1'b0) begin failures++; $display("FAIL flush_state got=%b/%b want=0/0", bus.busy, bus.completed); end
    checks++; if (bus.result !== 32'hFFFF_FFFD) begin failures++; $display("FAIL flush_result got=%h want=fffffffd", bus.result); end
    drive(6'd19, 32'd2, 32'd3, 32'd0, 32'd0);
    tick; bus.enabled = 1'b0;
    checks++; if (bus.completed !== 1'b1 || bus.result !== 32'd5) begin failures++; $display("FAIL add_after_flush got=%h/%b want=5/1", bus.result, bus.completed); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin tick; if (bus.completed === 1'b1) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL stale_completion got=%0d want=0", seen); end
  endtask

  task automatic test_reset_midop;
    drive(6'd34, 32'd100, 32'd3, 32'd0, 32'd0);
    tick; bus.enabled = 1'b0;
    tick; rstn = 1'b0; tick; rstn = 1'b1;
    checks++; if (bus.busy !== 1'b0 || bus.result !== 32'd0) begin failures++; $display("FAIL reset_midop got=%b/%h want=0/0", bus.busy, bus.result); end
    for (int i = 0; i < 40; i++) begin
      tick;
      if (bus.completed === 1'b1) begin checks++; failures++; $display("FAIL reset_midop_completion at=%0d want=none", i); end
    end
  endtask
`else
  task automatic test_no_muldiv;
    for (int op = 29; op <= 36; op += 7) begin
      drive(6'(op), 32'd3, 32'd4, 32'd0, 32'd0);
      tick; bus.enabled = 1'b0;
      checks++; if (bus.completed !== 1'b1 || bus.busy !== 1'b0 || bus.result !== 32'd0)
        begin failures++; $display("FAIL nomd_op%0d got=%h/%b/%b want=0/1/0", op, bus.result, bus.completed, bus.busy); end
      tick;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_addi;
    test_back_to_back;
    test_alu_table;
    test_forward;
    test_flush_priority;
`ifdef EXEC_MULDIV_EN
    test_mul;
    test_div;
    test_flush_div;
    test_reset_midop;
`else
    test_no_muldiv;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
